// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request and cache bus bundle for mem_access_ctrl
// slave = the sequencer; master = datapath control plus data cache.
interface mem_access_ctrl_if #(
  parameter int N = 32
);
  logic         req;
  logic         we;
  logic [1:0]   size;
  logic         sign_ext;
  logic         is_inst;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] rdata;
  logic [N-1:0] c_addr;
  logic [N-1:0] c_din;
  logic [1:0]   c_op;
  logic         c_inst;
  logic [N-1:0] c_dout;

  modport slave (
    input  req, we, size, sign_ext, is_inst, addr, wdata, c_dout,
    output busy, done, err, rdata, c_addr, c_din, c_op, c_inst
  );

  modport master (
    output req, we, size, sign_ext, is_inst, addr, wdata, c_dout,
    input  busy, done, err, rdata, c_addr, c_din, c_op, c_inst
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte/half/word load-store sequencer for a word cache
// Big-endian lanes; sub-word stores are read-modify-write; misaligned requests never reach the cache.
module mem_access_ctrl #(
  parameter int N     = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE,
    S_ERR
  } state_t;

  state_t       state;
  logic [1:0]   l_size;
  logic         l_sign;
  logic [1:0]   l_off;
  logic [15:0]  l_wdata;
  logic         busy_q, done_q, err_q, c_inst_q;
  logic [1:0]   c_op_q;
  logic [N-1:0] rdata_q, c_addr_q, c_din_q;

  logic         misaligned;
  logic         is_word;
  logic [7:0]   lane_b;
  logic [15:0]  lane_h;
  logic [N-1:0] load_val;
  logic [N-1:0] merged;

  // size 11 behaves as a word everywhere
  assign is_word    = bus.size[1];
  assign misaligned = (bus.size == 2'b01 && bus.addr[0]) ||
                      (is_word && bus.addr[1:0] != 2'b00);

  always_comb begin
    lane_b = 8'h00;
    case (l_off)
      2'd0:    lane_b = bus.c_dout[N-1  -: 8];
      2'd1:    lane_b = bus.c_dout[N-9  -: 8];
      2'd2:    lane_b = bus.c_dout[N-17 -: 8];
      default: lane_b = bus.c_dout[N-25 -: 8];
    endcase
    lane_h = l_off[1] ? bus.c_dout[N-17 -: 16] : bus.c_dout[N-1 -: 16];

    case (l_size)
      2'b00:   load_val = {{(N-8){l_sign & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{(N-16){l_sign & lane_h[15]}}, lane_h};
      default: load_val = bus.c_dout;
    endcase

    // c_din doubles as the merge register: the read word with one lane replaced
    merged = bus.c_dout;
    if (l_size == 2'b00) begin
      case (l_off)
        2'd0:    merged[N-1  -: 8] = l_wdata[7:0];
        2'd1:    merged[N-9  -: 8] = l_wdata[7:0];
        2'd2:    merged[N-17 -: 8] = l_wdata[7:0];
        default: merged[N-25 -: 8] = l_wdata[7:0];
      endcase
    end else if (l_off[1]) begin
      merged[N-17 -: 16] = l_wdata;
    end else begin
      merged[N-1 -: 16] = l_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      l_size   <= 2'b00;
      l_sign   <= 1'b0;
      l_off    <= 2'b00;
      l_wdata  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      c_addr_q <= '0;
      c_din_q  <= '0;
      c_op_q   <= OP_IDLE;
      c_inst_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            l_size   <= bus.size;
            l_sign   <= bus.sign_ext;
            l_off    <= bus.addr[1:0];
            l_wdata  <= bus.wdata[15:0];
            c_addr_q <= {{(N-IDX_W){1'b0}}, bus.addr[IDX_W+1:2]};
            c_inst_q <= bus.is_inst;
            busy_q   <= 1'b1;
            if (misaligned) begin
              state  <= S_ERR;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (!bus.we) begin
              state  <= S_READ;
              c_op_q <= OP_RD;
            end else if (is_word) begin
              state   <= S_WRITE;
              c_op_q  <= OP_WR;
              c_din_q <= bus.wdata;
            end else begin
              state  <= S_RMW_RD;
              c_op_q <= OP_RD;
            end
          end
        end
        S_READ: begin
          rdata_q <= load_val;
          c_op_q  <= OP_IDLE;
          done_q  <= 1'b1;
          state   <= S_DONE;
        end
        S_WRITE: begin
          c_op_q <= OP_IDLE;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_RMW_RD: begin
          c_din_q <= merged;
          c_op_q  <= OP_WR;
          state   <= S_RMW_WR;
        end
        S_RMW_WR: begin
          c_op_q <= OP_IDLE;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE, S_ERR: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          c_op_q <= OP_IDLE;
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.c_addr = c_addr_q;
  assign bus.c_din  = c_din_q;
  assign bus.c_op   = c_op_q;
  assign bus.c_inst = c_inst_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - random and directed bench for mem_access_ctrl
// Transaction-level model predicts per-cycle outputs; a negedge process compares them.
module tb_mem_access_ctrl;
  localparam int N     = 32;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  mem_access_ctrl_if #(.N(N)) bus ();
  mem_access_ctrl #(.N(N), .IDX_W(IDX_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] cmem [64];
  logic [31:0] ref_mem [64];
  assign bus.c_dout = cmem[bus.c_addr[5:0]];
  always @(posedge clk) if (bus.c_op == 2'b10) cmem[bus.c_addr[5:0]] <= bus.c_din;

  // staged plan (built at request time) and committed plan (at acceptance)
  int          s_len, p_len, t_acc;
  logic [1:0]  s_ops [2];
  logic [1:0]  p_ops [2];
  logic        s_err, p_err, s_load, p_load, s_store, p_store, s_inst, p_inst;
  logic [31:0] s_din, p_din, s_idx, p_idx, s_rnew, p_rnew, p_rold;
  logic [31:0] m_rdata = 32'h0;
  bit          act = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic int lane_shift(input logic [1:0] s, input logic [31:0] a);
    int n = nbytes(s);
    int o = int'(a[1:0]);
    if (n == 2) o = o & 2;
    if (n == 4) o = 0;
    return 8 * (4 - o - n);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] s);
    int n = nbytes(s);
    return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  function automatic logic [31:0] get_lane(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] s, input logic se);
    logic [31:0] m = lane_mask(s);
    logic [31:0] v = (word >> lane_shift(s, a)) & m;
    int n = nbytes(s);
    if (se && n < 4 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] s, input logic [31:0] d);
    logic [31:0] m  = lane_mask(s);
    int          sh = lane_shift(s, a);
    return (word & ~(m << sh)) | ((d & m) << sh);
  endfunction

  task automatic stage(input logic w, input logic [1:0] sz, input logic se, input logic ins,
                       input logic [31:0] a, input logic [31:0] d);
    int  n   = nbytes(sz);
    bit  mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    s_idx   = {26'd0, a[7:2]};
    s_inst  = ins;
    s_err   = mis;
    s_load  = 1'b0;
    s_store = 1'b0;
    s_ops[0] = 2'b00;
    s_ops[1] = 2'b00;
    s_din   = 32'h0;
    s_rnew  = 32'h0;
    if (mis) begin
      s_len = 1;
    end else if (!w) begin
      s_len = 2; s_ops[0] = 2'b01; s_load = 1'b1;
      s_rnew = get_lane(ref_mem[a[7:2]], a, sz, se);
    end else if (n == 4) begin
      s_len = 2; s_ops[0] = 2'b10; s_store = 1'b1; s_din = d;
    end else begin
      s_len = 3; s_ops[0] = 2'b01; s_ops[1] = 2'b10; s_store = 1'b1;
      s_din = put_lane(ref_mem[a[7:2]], a, sz, d);
    end
  endtask

  task automatic commit();
    p_len = s_len; p_ops[0] = s_ops[0]; p_ops[1] = s_ops[1];
    p_err = s_err; p_load = s_load; p_store = s_store; p_inst = s_inst;
    p_din = s_din; p_idx = s_idx; p_rnew = s_rnew; p_rold = m_rdata;
    t_acc = cyc;
    act   = 1'b1;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic se, input logic ins,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = se;
    bus.is_inst = ins; bus.addr = a; bus.wdata = d;
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic se, input logic ins,
                      input logic [31:0] a, input logic [31:0] d, input bit poke);
    @(negedge clk);
    drive(w, sz, se, ins, a, d);
    stage(w, sz, se, ins, a, d);
    @(posedge clk); #1;
    commit();
    if (poke) drive(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
    else bus.req = 1'b0;
    repeat (p_len) @(posedge clk);
    #1;
    bus.req = 1'b0;
    if (p_load) m_rdata = p_rnew;
    if (p_store) ref_mem[p_idx[5:0]] = p_din;
  endtask

  always @(negedge clk) begin : cmp
    int          j;
    logic        e_busy, e_done, e_err;
    logic [1:0]  e_op;
    logic [31:0] e_rd;
    if (act) begin
      j = cyc - t_acc;
      if (j < p_len) begin
        e_busy = 1'b1;
        e_op   = (j < p_len - 1) ? p_ops[j[0]] : 2'b00;
        e_done = (j == p_len - 1);
        e_err  = e_done & p_err;
      end else begin
        e_busy = 1'b0; e_op = 2'b00; e_done = 1'b0; e_err = 1'b0;
      end
      e_rd = (p_load && j >= p_len - 1) ? p_rnew : p_rold;
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("err", bus.err, e_err);
      chk("c_op", bus.c_op, e_op);
      chk("rdata", bus.rdata, e_rd);
      if (j < p_len) begin
        chk("c_addr", bus.c_addr, p_idx);
        chk("c_inst", bus.c_inst, p_inst);
      end
      if (e_op == 2'b10) chk("c_din", bus.c_din, p_din);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      cmem[i]    = $urandom;
      ref_mem[i] = cmem[i];
    end
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.is_inst = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_c_op", bus.c_op, 2'b00);
    chk("rst_c_addr", bus.c_addr, 32'h0);
    chk("rst_c_din", bus.c_din, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // word store / load round trip
    xact(1'b1, 2'b10, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lit_word", bus.rdata, 32'hDEADBEEF);

    // signed / unsigned byte loads
    xact(1'b1, 2'b10, 1'b0, 1'b1, 32'h10, 32'h12F45678, 1'b0);
    xact(1'b0, 2'b00, 1'b1, 1'b1, 32'h11, 32'h0, 1'b0);
    chk("lit_lb_s", bus.rdata, 32'hFFFFFFF4);
    xact(1'b0, 2'b00, 1'b0, 1'b0, 32'h11, 32'h0, 1'b0);
    chk("lit_lb_u", bus.rdata, 32'h000000F4);

    // byte RMW
    xact(1'b1, 2'b10, 1'b0, 1'b0, 32'h10, 32'h11223344, 1'b0);
    xact(1'b1, 2'b00, 1'b0, 1'b0, 32'h13, 32'h000000AA, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lit_sb", bus.rdata, 32'h112233AA);

    // half load / half RMW
    xact(1'b1, 2'b10, 1'b0, 1'b0, 32'h10, 32'h8001C0DE, 1'b0);
    xact(1'b0, 2'b01, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
    chk("lit_lh_s", bus.rdata, 32'hFFFFC0DE);
    xact(1'b1, 2'b01, 1'b0, 1'b0, 32'h10, 32'h00007777, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lit_sh", bus.rdata, 32'h7777C0DE);

    // misaligned with req held while busy
    xact(1'b0, 2'b01, 1'b1, 1'b0, 32'h13, 32'h0, 1'b1);
    chk("lit_mis_rdata", bus.rdata, 32'h7777C0DE);
    xact(1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1);

    // reset asserted during the write half of a byte RMW
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 32'h21, 32'h55);
    stage(1'b1, 2'b00, 1'b0, 1'b1, 32'h21, 32'h55);
    @(posedge clk); #1;
    commit();
    bus.req = 1'b0;
    @(posedge clk); #2;
    chk("rmw_wr_op", bus.c_op, 2'b10);
    act   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_c_op", bus.c_op, 2'b00);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_rdata", bus.rdata, 32'h0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_c_inst", bus.c_inst, 1'b0);
    m_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b1, 2'b10, 1'b0, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0);
    xact(1'b0, 2'b00, 1'b0, 1'b0, 32'h21, 32'h0, 1'b0);
    chk("lit_post_rst", bus.rdata, 32'h000000FE);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      xact(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
           ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
